// File: rtl/immediate_select_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_sel_pkg
// Shared definitions for the immediate select pipeline:
//   - imm_fmt_e        : format codes carried in select[2:0]
//   - SEL_UNSIGNED_BIT : select bit that requests zero-extension
//   - imm_extract()    : pure combinational immediate extractor
//   - imm_is_illegal() : flags the two reserved format codes
// Used by immediate_select_pipe and imm_sel_stage.
// -----------------------------------------------------------------------------
package imm_sel_pkg;

  typedef enum logic [2:0] {
    IMM_U     = 3'd0,
    IMM_J     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_I     = 3'd4,
    IMM_SHAMT = 3'd5
  } imm_fmt_e;

  localparam int unsigned SEL_UNSIGNED_BIT = 3;
  localparam int unsigned MAX_XLEN         = 64;

  // Codes 110 and 111 carry no immediate.
  function automatic logic imm_is_illegal(input logic [3:0] select);
    return (select[2:1] == 2'b11);
  endfunction

  // Returns the immediate extended to 64 bits; callers keep the low XLEN
  // bits. Every non-shift format has instr[31] as the top bit of its raw
  // field, so a single extension bit covers all of them. rv64 only affects
  // the shift-amount width.
  function automatic logic [MAX_XLEN-1:0] imm_extract(
    input logic [31:0] instr,
    input logic [3:0]  select,
    input logic        rv64 = 1'b0
  );
    logic [MAX_XLEN-1:0] res;
    logic                ext;
    ext = select[SEL_UNSIGNED_BIT] ? 1'b0 : instr[31];
    res = '0;
    case (select[2:0])
      IMM_U:     res = {{32{ext}}, instr[31:12], 12'b0};
      IMM_J:     res = {{43{ext}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      IMM_S:     res = {{52{ext}}, instr[31:25], instr[11:7]};
      IMM_B:     res = {{51{ext}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_I:     res = {{52{ext}}, instr[31:20]};
      // Shift amounts are never sign-extended.
      IMM_SHAMT: res = rv64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/immediate_select_pipe_stage.sv
// -----------------------------------------------------------------------------
// imm_sel_stage
// One elastic register stage of the immediate pipeline. Holds a valid bit,
// the immediate, the tag and (with IMM_SEL_ILLEGAL_EN) an illegal flag.
//
// Handshake: a beat transfers on an edge where valid and ready are both high
// on the same side. in_ready_o = !valid_q || out_ready_i, so a stage refills
// whenever it is empty or its current entry leaves this edge; ready may thus
// ripple combinationally from the consumer upward, valid never depends on
// ready.
//
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   flush_i                : clears valid_q (data kept)
//   in_valid_i/in_ready_o  : upstream handshake
//   in_data_i, in_tag_i    : upstream payload
//   in_illegal_i           : upstream illegal flag (IMM_SEL_ILLEGAL_EN only)
//   out_valid_o/out_ready_i: downstream handshake
//   out_data_o, out_tag_o  : registered payload
//   out_illegal_o          : registered illegal flag (IMM_SEL_ILLEGAL_EN only)
// -----------------------------------------------------------------------------
module imm_sel_stage
  import imm_sel_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    in_data_i,
  input  logic [TAG_W-1:0] in_tag_i,
`ifdef IMM_SEL_ILLEGAL_EN
  input  logic             in_illegal_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    out_data_o,
  output logic [TAG_W-1:0] out_tag_o
`ifdef IMM_SEL_ILLEGAL_EN
  ,
  output logic             out_illegal_o
`endif
);

  logic             valid_q, valid_d;
  logic [DW-1:0]    data_q,  data_d;
  logic [TAG_W-1:0] tag_q,   tag_d;
  logic             load;

`ifdef IMM_SEL_ILLEGAL_EN
  logic             ill_q, ill_d;
`endif

  assign load       = !valid_q || out_ready_i;
  assign in_ready_o = load;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
`ifdef IMM_SEL_ILLEGAL_EN
    ill_d   = ill_q;
`endif
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = in_valid_i;
      // Payload only moves with a real beat so an idle stage keeps its value.
      if (in_valid_i) begin
        data_d = in_data_i;
        tag_d  = in_tag_i;
`ifdef IMM_SEL_ILLEGAL_EN
        ill_d  = in_illegal_i;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
`ifdef IMM_SEL_ILLEGAL_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
`ifdef IMM_SEL_ILLEGAL_EN
      ill_q   <= ill_d;
`endif
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_tag_o   = tag_q;
`ifdef IMM_SEL_ILLEGAL_EN
  assign out_illegal_o = ill_q;
`endif

endmodule

// File: rtl/immediate_select_pipe.sv
// -----------------------------------------------------------------------------
// immediate_select_pipe
// Pipelined RV32IM/RV64 immediate selector. An instruction and a 4-bit
// select code are accepted over a valid/ready handshake, the immediate is
// extracted and extended combinationally at the input, and the result plus
// tag travel through DEPTH elastic imm_sel_stage registers.
//
// Optional feature macro: IMM_SEL_ILLEGAL_EN adds the out_illegal port and a
// per-entry illegal flag for select codes 110/111.
//
// Parameters: XLEN (32 or 64), DEPTH (1..4), TAG_W.
// Ports:
//   CLK, RESET (sync, active low), flush (kills all in-flight entries)
//   in_valid/in_ready, in_instr, in_select, in_tag : input beat
//   out_valid/out_ready, out_imm, out_tag          : output beat
//   out_illegal                                    : IMM_SEL_ILLEGAL_EN only
//
// Handshake: valid/ready; a beat moves on an edge with both high. in_ready is
// low during reset and flush so a concurrent beat is never taken.
// -----------------------------------------------------------------------------
module immediate_select_pipe
  import imm_sel_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [3:0]       in_select,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_SEL_ILLEGAL_EN
  ,
  output logic             out_illegal
`endif
);

  // Chain nets: index k is the input side of stage k, index DEPTH is the
  // pipeline output.
  logic             vld [DEPTH+1];
  logic             rdy [DEPTH+1];
  logic [XLEN-1:0]  dat [DEPTH+1];
  logic [TAG_W-1:0] tag [DEPTH+1];
`ifdef IMM_SEL_ILLEGAL_EN
  logic             ill [DEPTH+1];
`endif

  logic [MAX_XLEN-1:0] imm_full;
  logic                unused_imm_hi;

  assign imm_full      = imm_extract(in_instr, in_select, (XLEN == 64));
  // For XLEN=32 the top half of the extractor result is unused.
  assign unused_imm_hi = ^imm_full;

  assign in_ready = rdy[0] && !flush && RESET;
  assign vld[0]   = in_valid && in_ready;
  assign dat[0]   = imm_full[XLEN-1:0];
  assign tag[0]   = in_tag;
`ifdef IMM_SEL_ILLEGAL_EN
  assign ill[0]   = imm_is_illegal(in_select);
`endif

  assign rdy[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    imm_sel_stage #(
      .DW    (XLEN),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk_i        (CLK),
      .rst_ni       (RESET),
      .flush_i      (flush),
      .in_valid_i   (vld[k]),
      .in_ready_o   (rdy[k]),
      .in_data_i    (dat[k]),
      .in_tag_i     (tag[k]),
`ifdef IMM_SEL_ILLEGAL_EN
      .in_illegal_i (ill[k]),
`endif
      .out_valid_o  (vld[k+1]),
      .out_ready_i  (rdy[k+1]),
      .out_data_o   (dat[k+1]),
      .out_tag_o    (tag[k+1])
`ifdef IMM_SEL_ILLEGAL_EN
      ,
      .out_illegal_o(ill[k+1])
`endif
    );
  end

  assign out_valid = vld[DEPTH];
  assign out_imm   = dat[DEPTH];
  assign out_tag   = tag[DEPTH];
`ifdef IMM_SEL_ILLEGAL_EN
  assign out_illegal = ill[DEPTH];
`endif

endmodule

// File: doc/immediate_select_pipe.md
# immediate_select_pipe

Parametrised, pipelined successor to the combinational immediate selector in the RV32IM decode path. Accepts a 32-bit instruction plus a 4-bit select code through a valid/ready handshake, extracts and extends the immediate to XLEN bits, and presents it through `DEPTH` elastic register stages. It also carries a tag, supports pipeline flush, and sustains full throughput under backpressure. It sits between instruction decode and the operand-select/ALU stage.

## Interface
- `XLEN`, 32: output immediate width; legal values are 32 and 64.
- `DEPTH`, 2: number of elastic register stages; legal range is 1..4.
- `TAG_W`, 5: width of the sideband tag (e.g. ROB index or destination register).
- `CLK` input, 1: sole clock; all state updates on the rising edge.
- `RESET` input, 1: synchronous, active-low reset.
- `flush` input, 1: synchronous kill of all in-flight entries.
- `in_valid` input, 1: input beat present.
- `in_ready` output, 1: block accepts the beat this cycle.
- `in_instr` input, 32: raw instruction.
- `in_select` input, 4: immediate format select. Bit 3 set means zero-extend; bit 3 clear means sign-extend.
- `in_tag` input, `TAG_W`: sideband tag, passed through unchanged.
- `out_valid` output, 1: result present.
- `out_ready` input, 1: consumer takes the result this cycle.
- `out_imm` output, `XLEN`: extended immediate.
- `out_tag` output, `TAG_W`: tag aligned with `out_imm`.
- `out_illegal` output, 1: only present with `IMM_SEL_ILLEGAL_EN`.

## Operation
- Format codes in `in_select[2:0]`; extension applies from the top bit of the raw field:
  - 000 U: `{instr[31:12], 12'b0}`.
  - 001 J: `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}`.
  - 010 S: `{instr[31:25], instr[11:7]}`.
  - 011 B: `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`.
  - 100 I: `instr[31:20]`.
  - 101 SHAMT: `instr[24:20]` when XLEN=32, `instr[25:20]` when XLEN=64. Always zero-extended, regardless of bit 3.
  - 110 and 111: illegal. The immediate is 0.
- Extraction is combinational at the input. The result and tag are captured into stage 0 and advance one stage per cycle while the downstream stage is empty or being drained.
- Stage k holds `valid_k`, `imm_k` and `tag_k`. Stage k may load when `!valid_k || ready_k`, where `ready_k` is the load condition of the stage below it. The last stage's `ready` is `out_ready`.
- `in_ready` equals `(!valid_0 || ready_0) && !flush && RESET`.
- Bubbles collapse, so throughput is 1 beat/cycle with `out_ready` held high.

## Timing
- Reset (`RESET`=0 at an edge): all `valid_k`=0, `imm_k`=0, `tag_k`=0. Hence `out_valid`=0, `out_imm`=0, `out_tag`=0, `out_illegal`=0. `in_ready`=0 while `RESET`=0.
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N+DEPTH−1, i.e. `DEPTH` register stages, given no stall.
- Stall: while `out_valid && !out_ready`, `out_imm`, `out_tag` and `out_illegal` hold stable. Upstream stages keep filling until every stage is valid; then `in_ready`=0.
- Flush: on an edge with `flush`=1, every `valid_k` is cleared. A concurrent input beat is dropped (`in_ready` is 0). Data registers may keep stale values. `out_valid`=0 on the next cycle.
- Priority is reset > flush > normal advance.
- Reset mid-stream discards all entries identically to flush and additionally zeroes the data registers.
- `out_valid` never depends combinationally on `out_ready`. `in_ready` may depend combinationally on `out_ready`; this is an accepted ready path.

## Configuration
- `IMM_SEL_ILLEGAL_EN` defined:
  - The `out_illegal` port exists.
  - Select codes 110/111 set a per-stage illegal bit that travels with the entry.
  - The immediate for those codes is 0.
- Not defined:
  - The port and the bit are absent.
  - Codes 110/111 still produce 0.

## Structure
- Package `imm_sel_pkg` holds:
  - The format enum (`IMM_U`, `IMM_J`, `IMM_S`, `IMM_B`, `IMM_I`, `IMM_SHAMT`).
  - The select bit positions (`SEL_UNSIGNED_BIT`=3).
  - A pure function `imm_extract(instr, select)` returning the XLEN result.
- Sub-module `imm_sel_stage` is one elastic register stage: valid, data, tag and the optional illegal bit, with in/out handshake. The top level instantiates it `DEPTH` times in a generate loop.

## Test plan
- Formats, XLEN=32, DEPTH=2, `out_ready`=1:
  - 0x12345037 sel 0000 → 0x12345000.
  - 0x0080006F sel 0001 → 0x00000008.
  - 0xFE20AC23 sel 0010 → 0xFFFFFFF8.
  - 0xFE000EE3 sel 0011 → 0xFFFFFFFC.
  - 0xFFF00093 sel 0100 → 0xFFFFFFFF; sel 1100 → 0x00000FFF.
  - 0x4050D093 sel 0101 → 0x00000005.
  - Each result appears 2 cycles after acceptance.
- Back-to-back throughput: 8 consecutive beats with tags 0..7 and `out_ready`=1 → 8 consecutive `out_valid` cycles, tags in order, no bubbles.
- Backpressure: hold `out_ready`=0 for 5 cycles while driving beats → `in_ready` falls after `DEPTH` accepts. `out_imm` and `out_tag` stay stable. After release, all beats emerge in order with none lost or duplicated.
- Flush: with 2 entries in flight, assert `flush` for one cycle together with `in_valid` → `out_valid`=0 next cycle, and the flushed and concurrent beats never appear.
- Reset mid-operation: `RESET`=0 for one edge with a full pipe → all outputs 0 next cycle; the next accepted beat emerges after `DEPTH` cycles.
- XLEN=64 build: 0xFFF00093 sel 0100 → 0xFFFFFFFFFFFFFFFF. 0x03F0D093 sel 0101 → 0x000000000000003F. With `IMM_SEL_ILLEGAL_EN`, sel 0110 → imm 0 and `out_illegal`=1.
